// File: rtl/ring_decoder_mod6_if.sv
// Sample/status bundle between a ring-counter producer and its decoding monitor.
// The producer side drives the strobe and ring vector; the monitor returns decoded status.
interface ring_decoder_mod6_if #(
   parameter int N     = 6,
   parameter int IDX_W = 3,
   parameter int ERR_W = 8
);
   logic             en;
   logic [N-1:0]     ring_in;
   logic [IDX_W-1:0] idx;
   logic             idx_valid;
   logic             locked;
   logic             illegal;
   logic             seq_err;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output en, ring_in,
      input  idx, idx_valid, locked, illegal, seq_err, err_cnt
   );

   modport slave (
      input  en, ring_in,
      output idx, idx_valid, locked, illegal, seq_err, err_cnt
   );
endinterface

// File: rtl/ring_decoder_mod6.sv
// One-hot Mod-6 ring monitor: decodes the hot stage, tracks step-by-one advance
// through HUNT/CHECK/LOCKED, and reports illegal patterns and sequence breaks.
module ring_decoder_mod6 #(
   parameter int N     = 6,
   parameter int IDX_W = 3,
   parameter int ERR_W = 8
) (
   input logic              clk,
   input logic              clr,
   ring_decoder_mod6_if.slave bus
);
   localparam logic [1:0] S_HUNT   = 2'd0;
   localparam logic [1:0] S_CHECK  = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   function automatic logic is_legal(input logic [N-1:0] r);
      return (r != '0) && ((r & (r - N'(1))) == '0);
   endfunction

   function automatic logic [IDX_W-1:0] decode(input logic [N-1:0] r);
      logic [IDX_W-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++)
         if (r[i]) p = IDX_W'(i);
      return p;
   endfunction

   function automatic logic [IDX_W-1:0] next_pos(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(N - 1)) ? '0 : p + IDX_W'(1);
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
      return (c == '1) ? c : c + ERR_W'(1);
   endfunction

   logic [1:0]       state;
   logic             adv_once;   // one correct advance already seen while in CHECK
   logic [IDX_W-1:0] prev;
   logic             vld;
   logic             ill;
   logic             seq;
   logic [ERR_W-1:0] err;

   logic             legal;
   logic [IDX_W-1:0] pos;
   logic             hit;

   assign legal = is_legal(bus.ring_in);
   assign pos   = decode(bus.ring_in);
   assign hit   = (pos == next_pos(prev));

   // Sample stage: the strobed ring vector is judged and every status flop updated
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= S_HUNT;
         adv_once <= 1'b0;
         prev     <= '0;
         vld      <= 1'b0;
         ill      <= 1'b0;
         seq      <= 1'b0;
         err      <= '0;
      end else begin
         ill <= 1'b0;
         seq <= 1'b0;
         if (bus.en) begin
            if (!legal) begin
               ill      <= 1'b1;
               state    <= S_HUNT;
               adv_once <= 1'b0;
               err      <= sat_inc(err);
            end else begin
               prev <= pos;
               vld  <= 1'b1;
               case (state)
                  S_HUNT: begin
                     state    <= S_CHECK;
                     adv_once <= 1'b0;
                  end
                  S_CHECK: begin
                     if (hit && adv_once) begin
                        state    <= S_LOCKED;
                        adv_once <= 1'b0;
                     end else begin
                        adv_once <= hit;
                     end
                  end
                  S_LOCKED: begin
                     if (!hit) begin
                        seq      <= 1'b1;
                        err      <= sat_inc(err);
                        state    <= S_CHECK;
                        adv_once <= 1'b0;
                     end
                  end
                  default: begin
                     state    <= S_HUNT;
                     adv_once <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign bus.idx       = prev;
   assign bus.idx_valid = vld;
   assign bus.locked    = (state == S_LOCKED);
   assign bus.illegal   = ill;
   assign bus.seq_err   = seq;
   assign bus.err_cnt   = err;
endmodule
